nn_layer_sched: RTL
===================

// Module: nn_layer_sched
// PURPOSE
//  Sequencer in front of the nnctrl MAC/activation datapath. Captures one 16-bit sample per
//  input_signal rising edge into the feature buffer. After N_IN samples, steps the shared MAC
//  through hidden layer then output layer and arg-maxes the outputs into category.
//  Drives buffer write, weight/source addressing, MAC clear/enable and activation strobes.
// PARAMETERS
//  DW     16  sample / activation width (signed two's complement)
//  N_IN   8   samples per window = hidden-layer fan-in
//  N_HID  4   hidden neurons = output-layer fan-in
//  N_OUT  2   output neurons; CW = max(1,$clog2(N_OUT))
//  AW     8   width of w_addr, src_addr, buf_wr_addr, act_dst
// PORTS
//  clock         in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  input_signal  in   1   sample strobe; rising edge = new sample (level may last >=1 cycle)
//  in            in   DW  sample value, sampled on the rising-edge cycle
//  out_val       in   DW  output-neuron activation, valid the cycle after act_en (layer 2)
//  buf_wr_en     out  1   feature-buffer write strobe
//  buf_wr_addr   out  AW  write index 0..N_IN-1
//  buf_wr_data   out  DW  captured sample
//  mac_clr       out  1   clear accumulator
//  mac_en        out  1   accumulate src[src_addr]*W[w_addr]
//  src_sel       out  1   0 = feature buffer, 1 = hidden register file
//  src_addr      out  AW  operand index
//  w_addr        out  AW  weight ROM address
//  act_en        out  1   apply activation, write result to act_dst
//  act_dst       out  AW  hidden index (layer 1) or output index (layer 2)
//  busy          out  1   high in every state except FILL
//  done          out  1   1-cycle pulse, classification complete
//  category      out  CW  arg-max output index, held until next done
//  overrun       out  1   1-cycle pulse, sample strobe dropped
// BEHAVIOUR
//  Reset: all outputs 0. State FILL, sample count 0, edge-detect prev register = 1
//   (a strobe held high across reset release does NOT count as an edge).
//  Edge: rise = input_signal & ~prev, prev registered every cycle.
//  FILL: on rise, buf_wr_en=1, buf_wr_addr=count, buf_wr_data=in (registered, 1-cycle latency).
//   count++. After write N_IN-1 go to L1_CLR next cycle.
//  Rise in any state other than FILL (including DONE): no write, overrun=1 for one cycle.
//  L1 (h = 0..N_HID-1): L1_CLR 1 cycle mac_clr. L1_MAC N_IN cycles, mac_en=1, src_sel=0,
//   src_addr=i, w_addr=h*N_IN+i. L1_ACT 1 cycle act_en=1, act_dst=h.
//  L2 (o = 0..N_OUT-1): L2_CLR 1 cycle. L2_MAC N_HID cycles, src_sel=1, src_addr=h,
//   w_addr=N_HID*N_IN+o*N_HID+h. L2_ACT 1 cycle act_dst=o. L2_CMP 1 cycle samples out_val.
//  Arg-max: signed compare. o=0 always loads best. Later o replaces best only if strictly
//   greater (tie -> lower index).
//  DONE: 1 cycle, done=1, category<=best index in the same cycle. Next state FILL, count=0.
//   Windows are non-overlapping.
//  Latency: first mac_clr at T, done at T + N_HID*(N_IN+2) + N_OUT*(N_HID+3) (= T+54 at defaults).
//  mac_en/act_en/mac_clr mutually exclusive. Addresses are don't-care (held 0) when their
//   strobe is low.
//  Reset asserted mid-sequence: immediate return to reset values. Partial window and best
//   discarded. category cleared.
//  Counters never wrap: all counters compared against parameter-1 and cleared on each state exit.
// STRUCTURE
//  nn_sched_defs.vh: state encodings (FILL, L1_CLR, L1_MAC, L1_ACT, L2_CLR, L2_MAC, L2_ACT,
//   L2_CMP, DONE) and L2 weight base offset N_HID*N_IN.
//  Sub-module nn_sample_capture: edge detector + sample/count/overrun logic. Exports rise_ok
//   and window_full. FSM, address generation and arg-max stay in this module.
// TESTING
//  1 Reset low, input_signal=1, in=16'hFFFF -> all outputs 0. After release with input held
//    high: no buf_wr_en.
//  2 Eight 2-cycle pulses, in=0..7 -> exactly 8 writes, addr/data 0..7. busy rises the cycle
//    after 8th write.
//  3 Full run -> w_addr 0..31 on 32 mac_en, act_dst 0..3 in order. Then w_addr 32..39.
//    done at T+54, one cycle wide.
//  4 out_val model {5,-3} -> category 0. {-3,5} -> 1. {7,7} -> 0. {-8,-2} -> 1.
//  5 Pulse during L1_MAC and on DONE cycle -> overrun each, no write. Next window starts at addr 0.
//  6 Reset pulsed during L1_MAC h=2 -> outputs 0 asynchronously. Fresh 8-sample window gives
//    normal trace.

Source files
------------

// File: rtl/nn_layer_sched_pkg.sv
// Shared state encoding and derived constants for the nn_layer_sched sequencer.
package nn_layer_sched_pkg;

  typedef enum logic [3:0] {
    S_FILL,
    S_L1_CLR,
    S_L1_MAC,
    S_L1_ACT,
    S_L2_CLR,
    S_L2_MAC,
    S_L2_ACT,
    S_L2_CMP,
    S_DONE
  } state_t;

  // Output-layer weights sit directly after the hidden-layer block in the ROM.
  function automatic int l2_base(input int n_hid, input int n_in);
    return n_hid * n_in;
  endfunction

  function automatic int cw_of(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

endpackage

// File: rtl/nn_sample_capture.sv
// Sample-strobe edge detector, feature-buffer write port and window counter.
module nn_sample_capture #(
  parameter int DW   = 16,
  parameter int N_IN = 8,
  parameter int AW   = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          input_signal,
  input  logic [DW-1:0] in,
  input  logic          fill,
  output logic          rise_ok,
  output logic          window_full,
  output logic          buf_wr_en,
  output logic [AW-1:0] buf_wr_addr,
  output logic [DW-1:0] buf_wr_data,
  output logic          overrun
);

  logic          prev;
  logic          rise;
  logic [AW-1:0] count;
  logic          last;

  assign rise    = input_signal & ~prev;
  assign rise_ok = rise & fill;
  assign last    = (count == AW'(N_IN - 1));

  // prev resets high so a strobe held across reset release is not an edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev        <= 1'b1;
      count       <= '0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      window_full <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      prev        <= input_signal;
      buf_wr_en   <= rise_ok;
      buf_wr_addr <= rise_ok ? count : '0;
      buf_wr_data <= rise_ok ? in : '0;
      window_full <= rise_ok & last;
      overrun     <= rise & ~fill;
      if (rise_ok) count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/nn_layer_sched.sv
// Two-layer MAC sequencer: fills a sample window, walks hidden and output layers, arg-maxes.
module nn_layer_sched
  import nn_layer_sched_pkg::*;
#(
  parameter  int DW    = 16,
  parameter  int N_IN  = 8,
  parameter  int N_HID = 4,
  parameter  int N_OUT = 2,
  parameter  int AW    = 8,
  localparam int CW    = cw_of(N_OUT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          input_signal,
  input  logic [DW-1:0] in,
  input  logic [DW-1:0] out_val,
  output logic          buf_wr_en,
  output logic [AW-1:0] buf_wr_addr,
  output logic [DW-1:0] buf_wr_data,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          src_sel,
  output logic [AW-1:0] src_addr,
  output logic [AW-1:0] w_addr,
  output logic          act_en,
  output logic [AW-1:0] act_dst,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] category,
  output logic          overrun
);

  localparam int L2_BASE = l2_base(N_HID, N_IN);

  state_t                state, nxt;
  logic [AW-1:0]         mac_i;
  logic [AW-1:0]         neu;
  logic signed [DW-1:0]  best_val;
  logic [CW-1:0]         best_idx;
  logic                  fill;
  logic                  rise_ok;
  logic                  window_full;

  assign fill = (state == S_FILL);
  assign busy = ~fill;

  nn_sample_capture #(.DW(DW), .N_IN(N_IN), .AW(AW)) u_cap (
    .clock        (clock),
    .reset        (reset),
    .input_signal (input_signal),
    .in           (in),
    .fill         (fill),
    .rise_ok      (rise_ok),
    .window_full  (window_full),
    .buf_wr_en    (buf_wr_en),
    .buf_wr_addr  (buf_wr_addr),
    .buf_wr_data  (buf_wr_data),
    .overrun      (overrun)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_FILL;
    else        state <= nxt;
  end

  always_comb begin
    nxt      = state;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    act_en   = 1'b0;
    src_sel  = 1'b0;
    src_addr = '0;
    w_addr   = '0;
    act_dst  = '0;
    done     = 1'b0;
    case (state)
      S_FILL:   if (window_full) nxt = S_L1_CLR;
      S_L1_CLR: begin
        mac_clr = 1'b1;
        nxt     = S_L1_MAC;
      end
      S_L1_MAC: begin
        mac_en   = 1'b1;
        src_addr = mac_i;
        w_addr   = AW'(neu * N_IN) + mac_i;
        if (mac_i == AW'(N_IN - 1)) nxt = S_L1_ACT;
      end
      S_L1_ACT: begin
        act_en  = 1'b1;
        act_dst = neu;
        nxt     = (neu == AW'(N_HID - 1)) ? S_L2_CLR : S_L1_CLR;
      end
      S_L2_CLR: begin
        mac_clr = 1'b1;
        nxt     = S_L2_MAC;
      end
      S_L2_MAC: begin
        mac_en   = 1'b1;
        src_sel  = 1'b1;
        src_addr = mac_i;
        w_addr   = AW'(L2_BASE) + AW'(neu * N_HID) + mac_i;
        if (mac_i == AW'(N_HID - 1)) nxt = S_L2_ACT;
      end
      S_L2_ACT: begin
        act_en  = 1'b1;
        act_dst = neu;
        nxt     = S_L2_CMP;
      end
      S_L2_CMP: nxt = (neu == AW'(N_OUT - 1)) ? S_DONE : S_L2_CLR;
      S_DONE: begin
        done = 1'b1;
        nxt  = S_FILL;
      end
      default:  nxt = S_FILL;
    endcase
  end

  // Counters advance only while their state repeats and clear on every exit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mac_i    <= '0;
      neu      <= '0;
      best_val <= '0;
      best_idx <= '0;
      category <= '0;
    end else begin
      case (state)
        S_L1_MAC, S_L2_MAC: mac_i <= (nxt == state) ? mac_i + 1'b1 : '0;
        S_L1_ACT:           neu   <= (nxt == S_L1_CLR) ? neu + 1'b1 : '0;
        S_L2_CMP: begin
          // Strict greater-than keeps the lower index on ties.
          if (neu == '0 || $signed(out_val) > best_val) begin
            best_val <= $signed(out_val);
            best_idx <= CW'(neu);
          end
          neu <= (nxt == S_L2_CLR) ? neu + 1'b1 : '0;
        end
        S_DONE:             category <= best_idx;
        default: ;
      endcase
    end
  end

  a_rise_only_in_fill: assert property (@(posedge clock) disable iff (!reset)
    rise_ok |-> state == S_FILL);
  a_strobes_exclusive: assert property (@(posedge clock) disable iff (!reset)
    $onehot0({mac_clr, mac_en, act_en}));

endmodule
